// File: rtl/song_playback_ctrl.sv
// Song sequencer and note arbiter: steps an external note ROM at a selectable tempo
// (play/pause/stop/loop) and merges autoplay notes with manual keys, keys first.
module song_playback_ctrl #(
  parameter int unsigned DIV_BASE  = 12_500_000,
  parameter int unsigned LAST0     = 30,
  parameter int unsigned LAST1     = 31,
  parameter int unsigned STEP_W    = 6,
  parameter logic [3:0]  NOTE_NONE = 4'd0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  input  logic              song_sel,
  input  logic [3:0]        key_note,
  input  logic [3:0]        rom_data,
  output logic              rom_song,
  output logic [STEP_W-1:0] rom_addr,
  output logic [3:0]        note,
  output logic              beat_tick,
  output logic              playing,
  output logic              paused,
  output logic              song_done,
  output logic [1:0]        dbg_state
);

  localparam int unsigned DIV_W = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              song_q, song_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic [3:0]        note_q, note_d;

  logic [DIV_W-1:0]  term;
  logic [STEP_W-1:0] last_step;
  logic              boundary;

  assign term      = DIV_W'((DIV_BASE >> tempo_sel) - 1);
  assign last_step = song_q ? STEP_W'(LAST1) : STEP_W'(LAST0);
  // >= so that shrinking the tempo period mid-beat fires at once instead of wrapping
  assign boundary  = (div_q >= term);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    div_d   = div_q;
    song_d  = song_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        step_d = '0;
        div_d  = '0;
        if (btn_play && !btn_stop) begin
          state_d = S_PLAY;
          song_d  = song_sel;
        end
      end
      S_PLAY: begin
        if (btn_stop) begin
          state_d = S_IDLE;
          step_d  = '0;
          div_d   = '0;
        end else if (btn_play) begin
          state_d = S_PAUSE;
        end else if (boundary) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (step_q == last_step) begin
            done_d = 1'b1;
            step_d = '0;
            if (!loop_en) state_d = S_IDLE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_PAUSE: begin
        // div is held, so resuming keeps the remaining part of the beat
        if (btn_stop) begin
          state_d = S_IDLE;
          step_d  = '0;
          div_d   = '0;
        end else if (btn_play) begin
          state_d = S_PLAY;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        div_d   = '0;
      end
    endcase
    note_d = (key_note != NOTE_NONE) ? key_note
           : ((state_q == S_PLAY) ? rom_data : NOTE_NONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      div_q   <= '0;
      song_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      note_q  <= NOTE_NONE;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      div_q   <= div_d;
      song_q  <= song_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      note_q  <= note_d;
    end
  end

  assign rom_song  = song_q;
  assign rom_addr  = step_q;
  assign note      = note_q;
  assign beat_tick = tick_q;
  assign song_done = done_q;
  assign playing   = (state_q == S_PLAY);
  assign paused    = (state_q == S_PAUSE);
  assign dbg_state = state_q;

endmodule
